dp_result_capture: RTL
======================

Name: dp_result_capture

Overview:
Sink-side capture buffer for the 32-bit datapath circuits. It samples z/x result pairs each clock while a capture run is active and stores them in a DEPTH-entry FIFO. A downstream reader drains the FIFO over a valid/ready handshake. Overflow is tracked with a sticky flag and a saturating drop counter.

Parameters:
DATAWIDTH, 32, width of each z and x sample
DEPTH, 8, FIFO entries; must be a power of 2, at least 2
MAX_SAMPLES, 0, auto-stop after this many accepted samples per run; 0 = unlimited
DROPWIDTH, 8, width of the saturating drop counter

Ports:
Clk  input  1  system clock; all state updates on posedge
Reset  input  1  asynchronous, active-low reset; Reset=0 clears all state immediately
start  input  1  pulse: begin capture run
stop  input  1  pulse: end capture run
clear  input  1  pulse: flush FIFO, overflow, drop_cnt
cap_valid  input  1  z/x valid this cycle
z  input  DATAWIDTH  datapath result z
x  input  DATAWIDTH  datapath result x
rd_valid  output  1  head entry available
rd_ready  input  1  reader accepts head entry
rd_z  output  DATAWIDTH  head entry z
rd_x  output  DATAWIDTH  head entry x
count  output  clog2(DEPTH)+1  entries held
capturing  output  1  state==CAPTURE
overflow  output  1  sticky: a sample was dropped
drop_cnt  output  DROPWIDTH  dropped samples, saturating

Behaviour:
- Reset values: state IDLE; rd_valid=0, rd_z=0, rd_x=0, count=0, capturing=0, overflow=0, drop_cnt=0; pointers and run counter 0. Memory array is not reset.
- States:
  - IDLE: samples ignored. start -> CAPTURE.
  - CAPTURE: samples accepted. stop -> STOPPED. Run limit reached -> STOPPED.
  - STOPPED: samples ignored; reads continue. start -> CAPTURE.
- start in CAPTURE is ignored. start and stop in the same cycle: stop wins. From IDLE that means stay IDLE.
- start clears the run counter. It does not flush the FIFO.
- clear: flushes pointers, count, overflow and drop_cnt next cycle. The state is unchanged, except clear+start goes to CAPTURE with an empty FIFO. Any push or pop in a clear cycle is discarded.
- Push: state==CAPTURE and cap_valid and (not full, or pop in the same cycle). {z,x} is written at the tail on the posedge.
- Capture runs one cycle behind the control pulses: samples presented in the same cycle as start are ignored, and samples presented in the same cycle as stop are accepted.
- Drop: state==CAPTURE and cap_valid and full and no pop. Sets overflow. drop_cnt increments, saturating at all-ones.
- Pop: rd_valid and rd_ready. The head pointer advances.
- rd_valid = (count != 0). rd_z/rd_x show the head entry combinationally from storage and are forced to 0 when rd_valid=0.
- There is no bypass: a push into an empty FIFO makes rd_valid 1 on the next cycle. Latency from cap_valid to rd_valid is 1 clock.
- count: +1 on push only, -1 on pop only, unchanged on push+pop. Pointers wrap modulo DEPTH.
- MAX_SAMPLES != 0: the run counter increments per push. When a push makes it equal MAX_SAMPLES, state is STOPPED next cycle; no further pushes.
- Reset asserted mid-run: all state returns to reset values asynchronously. Partial contents are lost.

Optional Feature:
Macro: CAPTURE_TIMESTAMP_EN
- Defined:
  - A free-running 16-bit cycle counter runs from reset and wraps at 65535 -> 0.
  - Each pushed entry also stores the counter value at its push edge.
  - Adds output rd_ts [15:0], forced to 0 when rd_valid=0.
  - clear does not reset the timestamp counter.
- Not defined: no counter and no rd_ts port; everything else is identical.

Test Plan:
- Reset then start; one cycle later drive cap_valid with (z=3,x=1), (z=0,x=0), (z=5,x=2), rd_ready=0; stop -> count=3; rd_valid=1, rd_z=3, rd_x=1. Raise rd_ready -> 3, 0, 5 popped in order; then rd_valid=0, rd_z=0.
- DEPTH=8, rd_ready=0, cap_valid held 11 cycles in CAPTURE -> count=8, overflow=1, drop_cnt=3; first entry read out is the first sample.
- Full FIFO with rd_ready=1 and cap_valid=1 for 4 cycles -> count stays 8, no drops, overflow stays 0, output order preserved.
- MAX_SAMPLES=4, cap_valid held continuously after start -> exactly 4 entries, capturing falls the cycle after the 4th push, drop_cnt=0.
- start and stop in the same cycle from IDLE -> stays IDLE; stop+start in CAPTURE -> STOPPED. Then clear+start -> count=0, overflow=0, capturing=1.
- Reset pulsed low mid-run with count=5 -> rd_valid, count, overflow and drop_cnt drop to 0 immediately. With CAPTURE_TIMESTAMP_EN, pushes 10 cycles apart give rd_ts values differing by 10.

Source files
------------

// File: rtl/dp_result_capture.sv
// Sink-side capture FIFO for z/x datapath results with sticky overflow and saturating drop count.
// Optional CAPTURE_TIMESTAMP_EN stores a 16-bit push timestamp per entry and adds rd_ts.
module dp_result_capture #(
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned MAX_SAMPLES = 0,
  parameter int unsigned DROPWIDTH   = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  input  logic                   cap_valid,
  input  logic [DATAWIDTH-1:0]   z,
  input  logic [DATAWIDTH-1:0]   x,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATAWIDTH-1:0]   rd_z,
  output logic [DATAWIDTH-1:0]   rd_x,
  output logic [$clog2(DEPTH):0] count,
  output logic                   capturing,
  output logic                   overflow,
  output logic [DROPWIDTH-1:0]   drop_cnt
`ifdef CAPTURE_TIMESTAMP_EN
  ,
  output logic [15:0]            rd_ts
`endif
);
  // state   | meaning
  // IDLE    | after reset, samples ignored
  // CAPTURE | samples pushed into the FIFO
  // STOPPED | run ended, samples ignored, reads continue

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, STOPPED = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [DROPWIDTH-1:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]            run_cnt_q, run_cnt_d;
  logic [2*DATAWIDTH-1:0] mem_q [DEPTH];

  logic full, pop_req, push, pop, drop, run_done;

  assign full     = (count_q == CW'(DEPTH));
  assign pop_req  = (count_q != '0) && rd_ready;
  assign push     = (state_q == CAPTURE) && cap_valid && (!full || pop_req) && !clear;
  assign pop      = pop_req && !clear;
  assign drop     = (state_q == CAPTURE) && cap_valid && full && !pop_req && !clear;
  assign run_done = (MAX_SAMPLES != 0) && push && ((run_cnt_q + 32'd1) == 32'(MAX_SAMPLES));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    run_cnt_d  = run_cnt_q;

    if (push) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      run_cnt_d = run_cnt_q + 32'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end

    // stop outranks start; start only takes effect outside CAPTURE
    if (stop) begin
      if (state_q == CAPTURE) state_d = STOPPED;
    end else if (start && (state_q != CAPTURE)) begin
      state_d   = CAPTURE;
      run_cnt_d = '0;
    end else if (run_done) begin
      state_d = STOPPED;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      run_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= {z, x};
  end

  assign rd_valid  = (count_q != '0);
  assign rd_z      = rd_valid ? mem_q[rd_ptr_q][2*DATAWIDTH-1:DATAWIDTH] : '0;
  assign rd_x      = rd_valid ? mem_q[rd_ptr_q][DATAWIDTH-1:0] : '0;
  assign count     = count_q;
  assign capturing = (state_q == CAPTURE);
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef CAPTURE_TIMESTAMP_EN
  // free-running; clear leaves it alone so timestamps stay comparable across runs
  logic [15:0] ts_q, ts_d;
  logic [15:0] ts_mem_q [DEPTH];

  assign ts_d = ts_q + 16'd1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  always_ff @(posedge Clk) begin
    if (push) ts_mem_q[wr_ptr_q] <= ts_q;
  end

  assign rd_ts = rd_valid ? ts_mem_q[rd_ptr_q] : '0;
`endif

endmodule
